// File: rtl/sram_word_ctrl_if.sv
// ============================================================================
//  Module   : sram_word_ctrl_if
//  Brief    : Host request/response bundle for the word-wide SRAM controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface sram_word_ctrl_if #(
    parameter int AW    = 11,
    parameter int DW    = 8,
    parameter int BYTES = 2
);
    localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 0;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [AW-KW-1:0]      req_addr;
    logic [DW*BYTES-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [DW*BYTES-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/sram_word_ctrl.sv
// ============================================================================
//  Module   : sram_word_ctrl
//  Brief    : Splits host word accesses into timed byte cycles on an
//             asynchronous 6116-class SRAM (CSb/WEb/OEb, separate A/DQ).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sram_word_ctrl #(
    parameter int AW    = 11,
    parameter int DW    = 8,
    parameter int BYTES = 2,
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sram_word_ctrl_if.slave    host,
    output logic               sram_csb_o,
    output logic               sram_web_o,
    output logic               sram_oeb_o,
    output logic [AW-1:0]      sram_a_o,
    output logic [DW-1:0]      sram_dq_o,
    output logic               sram_dq_oe_o,
    input  wire logic [DW-1:0] sram_dq_i
);
    localparam int KW   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int BW   = (KW > 0) ? KW : 1;
    localparam int HAW  = AW - KW;
    localparam int WW   = DW * BYTES;
    localparam int MAXP = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                          : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [BW-1:0] LAST_K   = BW'(BYTES - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     k_q;
    logic              we_q;
    logic [HAW-1:0]    addr_q;
    logic [WW-1:0]     wdata_q;
    logic [WW-1:0]     rbuf_q;
    logic [WW-1:0]     rdata_q;
    logic              rsp_valid_q;
    logic              csb_q;
    logic              web_q;
    logic              oeb_q;
    logic [AW-1:0]     a_q;
    logic [DW-1:0]     dq_q;
    logic              dq_oe_q;

    logic [BW-1:0]     w_k_next;
    logic [AW-1:0]     w_addr_first;
    logic [AW-1:0]     w_addr_next;
    logic [WW-1:0]     w_wshift;
    logic [DW-1:0]     w_wbyte_next;

    assign w_k_next     = k_q + 1'b1;
    assign w_wshift     = wdata_q >> (DW * int'(w_k_next));
    assign w_wbyte_next = w_wshift[DW-1:0];

    // Byte index forms the low SRAM address bits, so no wrap at the top word.
    if (KW > 0) begin : g_multi
        assign w_addr_first = {host.req_addr, {KW{1'b0}}};
        assign w_addr_next  = {addr_q, w_k_next};
    end else begin : g_single
        assign w_addr_first = host.req_addr;
        assign w_addr_next  = addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            a_q         <= '0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (host.req_valid) begin
                        we_q    <= host.req_we;
                        addr_q  <= host.req_addr;
                        wdata_q <= host.req_wdata;
                        k_q     <= '0;
                        cnt_q   <= SETUP_LD;
                        state_q <= S_SETUP;
                        csb_q   <= 1'b0;
                        a_q     <= w_addr_first;
                        dq_q    <= host.req_wdata[DW-1:0];
                        dq_oe_q <= host.req_we;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= PULSE_LD;
                        state_q <= S_STROBE;
                        web_q   <= ~we_q;
                        oeb_q   <= we_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (cnt_q == '0) begin
                        // Sample the pad while OEb is still low on this edge.
                        if (!we_q) begin
                            rbuf_q[int'(k_q)*DW +: DW] <= sram_dq_i;
                        end
                        cnt_q   <= HOLD_LD;
                        state_q <= S_HOLD;
                        web_q   <= 1'b1;
                        oeb_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        if (k_q == LAST_K) begin
                            state_q     <= S_DONE;
                            csb_q       <= 1'b1;
                            dq_oe_q     <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            if (!we_q) begin
                                rdata_q <= rbuf_q;
                            end
                        end else begin
                            k_q     <= w_k_next;
                            cnt_q   <= SETUP_LD;
                            state_q <= S_SETUP;
                            a_q     <= w_addr_next;
                            dq_q    <= w_wbyte_next;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign host.req_ready = (state_q == S_IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rdata_q;

    assign sram_csb_o   = csb_q;
    assign sram_web_o   = web_q;
    assign sram_oeb_o   = oeb_q;
    assign sram_a_o     = a_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
endmodule

`default_nettype wire
